// File: rtl/bus_range_remap_pkg.sv
// bus_range_remap_pkg: shared helpers for mapping declared bus indices
// onto packed bit positions (position 0 holds the LSB-side declared index).
package bus_range_remap_pkg;

    localparam string MODE_INDEX    = "INDEX";
    localparam string MODE_POSITION = "POSITION";

    localparam int CNT_W = 16;

    function automatic int range_width(int msb, int lsb);
        return (msb >= lsb) ? (msb - lsb + 1) : (lsb - msb + 1);
    endfunction

    // Packed position of declared index idx in a bus [msb:lsb], or -1.
    function automatic int index_to_pos(int idx, int msb, int lsb);
        int pos;
        pos = -1;
        if (msb >= lsb) begin
            if (idx >= lsb && idx <= msb)
                pos = idx - lsb;
        end else begin
            if (idx >= msb && idx <= lsb)
                pos = lsb - idx;
        end
        return pos;
    endfunction

    function automatic int pos_to_index(int pos, int msb, int lsb);
        return (msb >= lsb) ? (lsb + pos) : (lsb - pos);
    endfunction

endpackage

// File: rtl/bus_range_remap_pipe_stage.sv
// remap_stage: one elastic register stage; it loads whenever it is empty
// or its own contents leave this cycle, so bubbles collapse.
module remap_stage
    import bus_range_remap_pkg::*;
#(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_flush,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_data
);

    logic         r_valid;
    logic [W-1:0] r_data;
    logic         w_adv;
    logic         w_load;

    assign w_adv   = r_valid & i_ready;
    assign o_ready = (~r_valid | w_adv) & ~i_flush;
    assign w_load  = o_ready & i_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_valid <= 1'b0;
        else if (i_flush)
            r_valid <= 1'b0;
        else if (o_ready)
            r_valid <= i_valid;
    end

    // Data path carries no reset; the valid flag qualifies it.
    always_ff @(posedge clk) begin
        if (w_load)
            r_data <= i_data;
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/bus_range_remap_pipe.sv
// bus_range_remap_pipe: elastic multi-lane pipe moving [I_MSB:I_LSB] lanes
// onto [O_MSB:O_LSB] lanes. Optional beat counter: BUS_RANGE_REMAP_CNT_EN.
module bus_range_remap_pipe
    import bus_range_remap_pkg::*;
#(
    parameter int    I_MSB    = 2,
    parameter int    I_LSB    = -2,
    parameter int    O_MSB    = -2,
    parameter int    O_LSB    = 2,
    parameter int    CHANNELS = 2,
    parameter int    DEPTH    = 2,
    parameter string MODE     = "INDEX",
    parameter logic  FILL     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flush,
    input  logic in_valid,
    output logic in_ready,
    input  logic [CHANNELS*range_width(I_MSB, I_LSB)-1:0] in_data,
    output logic out_valid,
    input  logic out_ready,
    output logic [CHANNELS*range_width(O_MSB, O_LSB)-1:0] out_data
`ifdef BUS_RANGE_REMAP_CNT_EN
    ,
    input  logic             count_clr,
    output logic [CNT_W-1:0] beat_count
`endif
);

    localparam int  WI       = range_width(I_MSB, I_LSB);
    localparam int  WO       = range_width(O_MSB, O_LSB);
    localparam int  WD       = CHANNELS * WO;
    localparam bit  IS_INDEX = (MODE == MODE_INDEX);
    localparam bit  IS_POS   = (MODE == MODE_POSITION);

    if (!IS_INDEX && !IS_POS) begin : g_bad_mode
        $error("bus_range_remap_pipe: MODE must be INDEX or POSITION");
    end

    logic [WD-1:0] w_remap;
    logic          w_valid [DEPTH+1];
    logic          w_ready [DEPTH+1];
    logic [WD-1:0] w_data  [DEPTH+1];

    // Pure wiring: each output bit picks one input bit or the fill value.
    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        for (genvar p = 0; p < WO; p++) begin : g_bit
            localparam int OIDX = pos_to_index(p, O_MSB, O_LSB);
            localparam int IP   = IS_INDEX ?
                                  index_to_pos(OIDX, I_MSB, I_LSB) :
                                  ((p < WI) ? p : -1);
            if (IP >= 0) begin : g_src
                assign w_remap[c*WO+p] = in_data[c*WI+IP];
            end else begin : g_fill
                assign w_remap[c*WO+p] = FILL;
            end
        end
    end

    assign w_valid[0]     = in_valid;
    assign w_data[0]      = w_remap;
    assign w_ready[DEPTH] = out_ready;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        remap_stage #(
            .W (WD)
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_flush (flush),
            .i_valid (w_valid[k]),
            .o_ready (w_ready[k]),
            .i_data  (w_data[k]),
            .o_valid (w_valid[k+1]),
            .i_ready (w_ready[k+1]),
            .o_data  (w_data[k+1])
        );
    end

    assign in_ready  = w_ready[0];
    assign out_valid = w_valid[DEPTH];
    // Idle output reads as zero since stage data is never reset.
    assign out_data  = w_valid[DEPTH] ? w_data[DEPTH] : '0;

`ifdef BUS_RANGE_REMAP_CNT_EN
    logic             w_out_xfer;
    logic [CNT_W-1:0] r_beat_count;

    assign w_out_xfer = w_valid[DEPTH] & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_beat_count <= '0;
        else if (count_clr)
            r_beat_count <= '0;
        else if (w_out_xfer && (r_beat_count != {CNT_W{1'b1}}))
            r_beat_count <= r_beat_count + 1'b1;
    end

    assign beat_count = r_beat_count;
`endif

endmodule

// File: tb/tb_bus_range_remap_pipe.sv
// tb_bus_range_remap_pipe: directed checks of remap, handshake, flush,
// reset and (with BUS_RANGE_REMAP_CNT_EN) the beat counter.
module tb_bus_range_remap_pipe;

    localparam int CH = 2;
    localparam int W  = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic [CH*W-1:0] in_data = '0;

    logic rdy_d, vld_d, rdy_p, vld_p, rdy_0, vld_0, rdy_1, vld_1;
    logic [CH*W-1:0] dat_d, dat_p, dat_0, dat_1;

`ifdef BUS_RANGE_REMAP_CNT_EN
    logic count_clr = 1'b0;
    logic [15:0] cnt_d, cnt_p, cnt_0, cnt_1;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // {lane1, lane0} beats and their INDEX-mode images (bit reversal)
    logic [CH*W-1:0] bp_in [4] = '{
        {5'b00001, 5'b10000}, {5'b00010, 5'b01100},
        {5'b10101, 5'b11010}, {5'b11110, 5'b00111}};
    logic [CH*W-1:0] bp_ex [4] = '{
        {5'b10000, 5'b00001}, {5'b01000, 5'b00110},
        {5'b10101, 5'b01011}, {5'b01111, 5'b11100}};

    always #5 clk = ~clk;

    bus_range_remap_pipe u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy_d), .in_data(in_data),
        .out_valid(vld_d), .out_ready(out_ready), .out_data(dat_d)
`ifdef BUS_RANGE_REMAP_CNT_EN
        , .count_clr(count_clr), .beat_count(cnt_d)
`endif
    );

    bus_range_remap_pipe #(.MODE("POSITION")) u_pos (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy_p), .in_data(in_data),
        .out_valid(vld_p), .out_ready(out_ready), .out_data(dat_p)
`ifdef BUS_RANGE_REMAP_CNT_EN
        , .count_clr(count_clr), .beat_count(cnt_p)
`endif
    );

    bus_range_remap_pipe #(.O_MSB(4), .O_LSB(0), .FILL(1'b0)) u_f0 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy_0), .in_data(in_data),
        .out_valid(vld_0), .out_ready(out_ready), .out_data(dat_0)
`ifdef BUS_RANGE_REMAP_CNT_EN
        , .count_clr(count_clr), .beat_count(cnt_0)
`endif
    );

    bus_range_remap_pipe #(.O_MSB(4), .O_LSB(0), .FILL(1'b1)) u_f1 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy_1), .in_data(in_data),
        .out_valid(vld_1), .out_ready(out_ready), .out_data(dat_1)
`ifdef BUS_RANGE_REMAP_CNT_EN
        , .count_clr(count_clr), .beat_count(cnt_1)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        n_cmp++;
        if (vld_d !== 1'b0 || vld_p !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_valid: got %b/%b want 0", vld_d, vld_p);
        end
        n_cmp++;
        if (dat_d !== '0) begin
            n_bad++;
            $display("FAIL reset_data: got %h want 0", dat_d);
        end
        tick();
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (rdy_d !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_ready: got %b want 1", rdy_d);
        end
        tick();
    endtask

    task automatic test_index();
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_data = {5'b00011, 5'b10000};
        tick();
        in_valid = 1'b0;
        in_data = '0;
        #1;
        n_cmp++;
        if (vld_d !== 1'b0) begin
            n_bad++;
            $display("FAIL latency_early: got %b want 0", vld_d);
        end
        tick();
        n_cmp++;
        if ({vld_d, dat_d} !== {1'b1, 5'b11000, 5'b00001}) begin
            n_bad++;
            $display("FAIL index_map: got %b_%h want 1_%h",
                     vld_d, dat_d, {5'b11000, 5'b00001});
        end
        n_cmp++;
        if ({vld_p, dat_p} !== {1'b1, 5'b00011, 5'b10000}) begin
            n_bad++;
            $display("FAIL position_map: got %b_%h want 1_%h",
                     vld_p, dat_p, {5'b00011, 5'b10000});
        end
        tick();
        n_cmp++;
        if (vld_d !== 1'b0) begin
            n_bad++;
            $display("FAIL index_drain: got %b want 0", vld_d);
        end
    endtask

    task automatic test_fill();
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_data = {5'b10110, 5'b10110};
        tick();
        in_valid = 1'b0;
        tick();
        n_cmp++;
        if ({vld_0, dat_0} !== {1'b1, 5'b00101, 5'b00101}) begin
            n_bad++;
            $display("FAIL fill0: got %b_%h want 1_%h",
                     vld_0, dat_0, {5'b00101, 5'b00101});
        end
        n_cmp++;
        if ({vld_1, dat_1} !== {1'b1, 5'b11101, 5'b11101}) begin
            n_bad++;
            $display("FAIL fill1: got %b_%h want 1_%h",
                     vld_1, dat_1, {5'b11101, 5'b11101});
        end
        n_cmp++;
        if (dat_d !== {5'b01101, 5'b01101}) begin
            n_bad++;
            $display("FAIL index_rev: got %h want %h",
                     dat_d, {5'b01101, 5'b01101});
        end
        tick();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid = (i < 4);
            in_data = (i < 4) ? bp_in[i] : '0;
            tick();
            if (i >= 1 && i <= 4) begin
                n_cmp++;
                if ({vld_d, dat_d} !== {1'b1, bp_ex[i-1]}) begin
                    n_bad++;
                    $display("FAIL b2b_beat%0d: got %b_%h want 1_%h",
                             i - 1, vld_d, dat_d, bp_ex[i-1]);
                end
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        int s;
        int r;
        logic acc;
        s = 0;
        r = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = (s < 4);
            in_data = (s < 4) ? bp_in[s] : '0;
            #1;
            acc = in_valid & rdy_d;
            tick();
            if (acc) s++;
        end
        in_valid = 1'b1;
        in_data = bp_in[s[1:0]];
        #1;
        n_cmp++;
        if (s != 2 || rdy_d !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_stall: got acc=%0d rdy=%b want 2/0", s, rdy_d);
        end
        n_cmp++;
        if ({vld_d, dat_d} !== {1'b1, bp_ex[0]}) begin
            n_bad++;
            $display("FAIL bp_hold: got %b_%h want 1_%h",
                     vld_d, dat_d, bp_ex[0]);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 20 && r < 4; i++) begin
            in_valid = (s < 4);
            in_data = (s < 4) ? bp_in[s] : '0;
            #1;
            acc = in_valid & rdy_d;
            if (vld_d === 1'b1) begin
                n_cmp++;
                if (dat_d !== bp_ex[r]) begin
                    n_bad++;
                    $display("FAIL bp_order%0d: got %h want %h",
                             r, dat_d, bp_ex[r]);
                end
                r++;
            end
            tick();
            if (acc) s++;
        end
        in_valid = 1'b0;
        #1;
        n_cmp++;
        if (r != 4 || s != 4 || vld_d !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_count: got rx=%0d tx=%0d vld=%b want 4/4/0",
                     r, s, vld_d);
        end
        tick();
    endtask

    task automatic test_flush();
        int seen;
        seen = 0;
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = bp_in[0];
        tick();
        in_data = bp_in[1];
        tick();
        flush = 1'b1;
        in_data = bp_in[2];
        #1;
        n_cmp++;
        if (rdy_d !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_ready: got %b want 0", rdy_d);
        end
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        #1;
        n_cmp++;
        if (vld_d !== 1'b0 || rdy_d !== 1'b1) begin
            n_bad++;
            $display("FAIL flush_clear: got vld=%b rdy=%b want 0/1",
                     vld_d, rdy_d);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (vld_d === 1'b1) seen++;
        end
        n_cmp++;
        if (seen != 0) begin
            n_bad++;
            $display("FAIL flush_ghost: got %0d beats want 0", seen);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = bp_in[3];
        tick();
        tick();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (vld_d !== 1'b0 || dat_d !== '0) begin
            n_bad++;
            $display("FAIL reset_mid: got %b_%h want 0_0", vld_d, dat_d);
        end
        tick();
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (rdy_d !== 1'b1 || vld_d !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid_rel: got rdy=%b vld=%b want 1/0",
                     rdy_d, vld_d);
        end
        tick();
    endtask

`ifdef BUS_RANGE_REMAP_CNT_EN
    task automatic test_count();
        n_cmp++;
        if (cnt_d !== 16'h0000) begin
            n_bad++;
            $display("FAIL cnt_reset: got %h want 0000", cnt_d);
        end
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_data = bp_in[0];
        for (int i = 0; i < 70002; i++) tick();
        n_cmp++;
        if (cnt_d !== 16'hFFFF) begin
            n_bad++;
            $display("FAIL cnt_sat: got %h want ffff", cnt_d);
        end
        count_clr = 1'b1;
        tick();
        count_clr = 1'b0;
        n_cmp++;
        if (cnt_d !== 16'h0000) begin
            n_bad++;
            $display("FAIL cnt_clr: got %h want 0000", cnt_d);
        end
        tick();
        n_cmp++;
        if (cnt_d !== 16'h0001) begin
            n_bad++;
            $display("FAIL cnt_inc: got %h want 0001", cnt_d);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_cmp++;
        if (cnt_d !== 16'h0002) begin
            n_bad++;
            $display("FAIL cnt_flush_xfer: got %h want 0002", cnt_d);
        end
        tick();
        n_cmp++;
        if (cnt_d !== 16'h0002) begin
            n_bad++;
            $display("FAIL cnt_flush_hold: got %h want 0002", cnt_d);
        end
        in_valid = 1'b0;
        tick();
        tick();
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_index();
        test_fill();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_reset_mid();
`ifdef BUS_RANGE_REMAP_CNT_EN
        test_count();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
